// File: rtl/kf_host_ctrl.sv
// Host-side driver for the Kalman filter core: loads one frame of measurement words into the
// Data Bank, pulses START, follows READY through the run and returns the final DATA_OUT.
module kf_host_ctrl #(
    parameter int W         = 24,
    parameter int ADDRW     = 5,
    parameter int NLOAD     = 4,
    parameter int BASE_ADDR = 0,
    parameter int START_TO  = 15,
    parameter int RUN_TO    = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W-1:0]     m_data,
    output logic             m_err,
    input  logic             kf_ready,
    input  logic [W-1:0]     kf_data_out,
    output logic [W-1:0]     kf_data_in,
    output logic [ADDRW-1:0] kf_dir,
    output logic             kf_write,
    output logic             kf_start,
    output logic [7:0]       frame_cnt
);

    localparam int CNTW   = $clog2(NLOAD + 1);
    localparam int TO_MAX = (START_TO > RUN_TO) ? START_TO : RUN_TO;
    localparam int TW     = $clog2(TO_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        OUT
    } state_t;

    state_t            state_reg, state_next;
    logic [CNTW-1:0]   cnt_reg, cnt_next;
    logic [TW-1:0]     timer_reg, timer_next;
    logic [W-1:0]      m_data_reg, m_data_next;
    logic              m_err_reg, m_err_next;
    logic [7:0]        frame_cnt_reg, frame_cnt_next;
    logic [W-1:0]      kf_data_in_reg, kf_data_in_next;
    logic [ADDRW-1:0]  kf_dir_reg, kf_dir_next;
    logic              kf_write_reg, kf_write_next;
    logic              kf_start_reg, kf_start_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            timer_reg      <= '0;
            m_data_reg     <= '0;
            m_err_reg      <= 1'b0;
            frame_cnt_reg  <= '0;
            kf_data_in_reg <= '0;
            kf_dir_reg     <= '0;
            kf_write_reg   <= 1'b0;
            kf_start_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            timer_reg      <= timer_next;
            m_data_reg     <= m_data_next;
            m_err_reg      <= m_err_next;
            frame_cnt_reg  <= frame_cnt_next;
            kf_data_in_reg <= kf_data_in_next;
            kf_dir_reg     <= kf_dir_next;
            kf_write_reg   <= kf_write_next;
            kf_start_reg   <= kf_start_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        timer_next      = timer_reg;
        m_data_next     = m_data_reg;
        m_err_next      = m_err_reg;
        frame_cnt_next  = frame_cnt_reg;
        kf_data_in_next = kf_data_in_reg;
        kf_dir_next     = kf_dir_reg;
        kf_write_next   = 1'b0;
        kf_start_next   = 1'b0;
        s_ready         = 1'b0;
        m_valid         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (kf_ready) state_next = LOAD;
            end
            LOAD: begin
                // Words are only accepted while the core reports idle; a READY drop just stalls.
                s_ready = kf_ready;
                if (s_valid && kf_ready) begin
                    kf_data_in_next = s_data;
                    kf_dir_next     = ADDRW'(BASE_ADDR) + ADDRW'(cnt_reg);
                    kf_write_next   = 1'b1;
                    cnt_next        = cnt_reg + CNTW'(1);
                    if (cnt_reg == CNTW'(NLOAD - 1)) state_next = START;
                end
            end
            START: begin
                kf_start_next = 1'b1;
                timer_next    = '0;
                state_next    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!kf_ready) begin
                    // Sample here too so a one-cycle busy period still yields its DATA_OUT.
                    m_data_next = kf_data_out;
                    timer_next  = '0;
                    state_next  = WAIT_DONE;
                end else if (int'(timer_reg) + 1 >= START_TO) begin
                    m_err_next = 1'b1;
                    state_next = OUT;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (kf_ready) begin
                    m_err_next = 1'b0;
                    state_next = OUT;
                end else begin
                    m_data_next = kf_data_out;
                    if (int'(timer_reg) + 1 >= RUN_TO) begin
                        m_err_next = 1'b1;
                        state_next = OUT;
                    end else begin
                        timer_next = timer_reg + TW'(1);
                    end
                end
            end
            OUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    frame_cnt_next = frame_cnt_reg + 8'd1;
                    m_err_next     = 1'b0;
                    cnt_next       = '0;
                    timer_next     = '0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign m_data     = m_data_reg;
    assign m_err      = m_err_reg;
    assign frame_cnt  = frame_cnt_reg;
    assign kf_data_in = kf_data_in_reg;
    assign kf_dir     = kf_dir_reg;
    assign kf_write   = kf_write_reg;
    assign kf_start   = kf_start_reg;

endmodule

// File: tb/tb_kf_host_ctrl.sv
// Bench for kf_host_ctrl: behavioural core model, stream driver and per-scenario checks
// against expectations derived from the frame/timeout rules.
module tb_kf_host_ctrl;

    localparam int W        = 24;
    localparam int ADDRW    = 5;
    localparam int NLOAD    = 4;
    localparam int BASE     = 8;
    localparam int START_TO = 15;
    localparam int RUN_TO   = 1023;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [W-1:0]     s_data = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [W-1:0]     m_data;
    logic             m_err;
    logic             kf_ready = 1'b1;
    logic [W-1:0]     kf_data_out = '0;
    logic [W-1:0]     kf_data_in;
    logic [ADDRW-1:0] kf_dir;
    logic             kf_write;
    logic             kf_start;
    logic [7:0]       frame_cnt;

    always #5 clk = ~clk;

    kf_host_ctrl #(
        .W(W), .ADDRW(ADDRW), .NLOAD(NLOAD), .BASE_ADDR(BASE),
        .START_TO(START_TO), .RUN_TO(RUN_TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_err(m_err),
        .kf_ready(kf_ready), .kf_data_out(kf_data_out),
        .kf_data_in(kf_data_in), .kf_dir(kf_dir), .kf_write(kf_write), .kf_start(kf_start),
        .frame_cnt(frame_cnt)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fc_exp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: START seen in cycle e makes READY low for cycles e+1..e+L,
    // with DATA_OUT equal to core_final in the last busy cycle.
    int           core_busy_len = 5;
    int           core_busy_left = 0;
    bit           core_hang = 1'b0;
    bit           load_drop = 1'b0;
    logic [W-1:0] core_final = '0;

    always @(negedge clk) begin
        if (core_busy_left > 0) begin
            kf_ready    = 1'b0;
            kf_data_out = (core_busy_left == 1) ? core_final : W'($urandom);
            core_busy_left--;
        end else begin
            kf_ready = !load_drop;
        end
        if (kf_start && !core_hang && core_busy_left == 0) core_busy_left = core_busy_len;
    end

    // Pin monitor: logs writes and start pulses, counts protocol violations.
    int               wr_cyc[$];
    logic [ADDRW-1:0] wr_dir[$];
    logic [W-1:0]     wr_dat[$];
    int               st_cyc[$];
    int               viol = 0;

    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (kf_write) begin
                wr_cyc.push_back(cyc);
                wr_dir.push_back(kf_dir);
                wr_dat.push_back(kf_data_in);
            end
            if (kf_start) st_cyc.push_back(cyc);
            if (s_ready && (!kf_ready || m_valid)) viol++;
            if (kf_write && kf_start) viol++;
        end
    end

    int           hs_cyc[$];
    logic [W-1:0] exp_dat[$];

    task automatic clear_logs();
        wr_cyc.delete();
        wr_dir.delete();
        wr_dat.delete();
        st_cyc.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        fc_exp = 0;
    endtask

    // Offers nwords words, one every `gap` cycles; after the drop_after-th acceptance
    // the core READY is pulled low for two cycles.
    task automatic drive_words(input int nwords, input int gap, input int drop_after,
                               input bit rnd, input logic [W-1:0] w0);
        int n = 0;
        int idle = 0;
        int guard = 0;
        int drop_left = 0;
        bit arm_drop = 1'b0;
        bit hs_prev = 1'b0;
        hs_cyc.delete();
        exp_dat.delete();
        while (n < nwords && guard < 3000) begin
            @(negedge clk);
            guard++;
            if (hs_prev) s_valid = 1'b0;
            hs_prev = 1'b0;
            if (!s_valid) begin
                if (idle >= gap - 1) begin
                    s_valid = 1'b1;
                    s_data  = rnd ? W'($urandom) : w0 + W'(n);
                    idle    = 0;
                end else begin
                    idle++;
                end
            end
            #2;
            if (drop_left > 0) begin
                drop_left--;
                if (drop_left == 0) load_drop = 1'b0;
            end
            if (arm_drop) begin
                load_drop = 1'b1;
                drop_left = 2;
                arm_drop  = 1'b0;
            end
            if (s_valid && s_ready) begin
                hs_cyc.push_back(cyc);
                exp_dat.push_back(s_data);
                n++;
                hs_prev = 1'b1;
                if (n == drop_after) arm_drop = 1'b1;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic get_result(input int stall, output int mv_cyc, output logic [W-1:0] d,
                              output logic e, output bit got, output bit stable);
        int g = 0;
        got = 1'b0;
        stable = 1'b1;
        mv_cyc = -1;
        d = '0;
        e = 1'b0;
        while (g < 3000 && !got) begin
            @(negedge clk);
            #1;
            g++;
            if (m_valid) got = 1'b1;
        end
        if (!got) return;
        mv_cyc = cyc;
        d = m_data;
        e = m_err;
        repeat (stall) begin
            @(negedge clk);
            #1;
            if (!m_valid || m_data !== d || m_err !== e || s_ready) stable = 1'b0;
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        fc_exp = (fc_exp + 1) % 256;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({s_ready, m_valid, m_err, m_data, kf_data_in, kf_dir, kf_write, kf_start, frame_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got s_ready=%b m_valid=%b m_err=%b m_data=%h din=%h dir=%0d wr=%b st=%b fc=%0d required all 0",
                     s_ready, m_valid, m_err, m_data, kf_data_in, kf_dir, kf_write, kf_start, frame_cnt);
        end
        rst_n = 1'b1;
        fc_exp = 0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int mv; logic [W-1:0] d; logic e; bit got, stab; int st;
        clear_logs();
        core_busy_len = 20;
        core_final = 24'h00ABCD;
        drive_words(NLOAD, 1, -1, 1'b0, 24'h000100);
        get_result(0, mv, d, e, got, stab);
        st = (st_cyc.size() > 0) ? st_cyc[0] : -1;
        checks++;
        if (wr_dir.size() != NLOAD || hs_cyc.size() != NLOAD) begin
            failures++;
            $display("FAIL basic_counts writes=%0d handshakes=%0d required %0d", wr_dir.size(), hs_cyc.size(), NLOAD);
        end
        for (int i = 0; i < NLOAD && i < wr_dir.size() && i < hs_cyc.size(); i++) begin
            checks++;
            if (wr_dir[i] !== ADDRW'(BASE + i) || wr_dat[i] !== W'(24'h000100 + i) ||
                wr_cyc[i] !== hs_cyc[0] + i + 1) begin
                failures++;
                $display("FAIL basic_write%0d got dir=%0d data=%h cyc=%0d required dir=%0d data=%h cyc=%0d",
                         i, wr_dir[i], wr_dat[i], wr_cyc[i], BASE + i, 24'h000100 + i, hs_cyc[0] + i + 1);
            end
        end
        checks++;
        if (st_cyc.size() != 1 || hs_cyc.size() == 0 || st !== hs_cyc[hs_cyc.size()-1] + 2) begin
            failures++;
            $display("FAIL basic_start pulses=%0d at=%0d required 1 pulse two cycles after last handshake", st_cyc.size(), st);
        end
        checks++;
        if (!got || mv !== st + core_busy_len + 2) begin
            failures++;
            $display("FAIL basic_result_time got=%0d required=%0d", mv, st + core_busy_len + 2);
        end
        checks++;
        if (d !== 24'h00ABCD || e !== 1'b0) begin
            failures++;
            $display("FAIL basic_result got data=%h err=%b required data=00abcd err=0", d, e);
        end
        checks++;
        if (frame_cnt !== 8'd1) begin
            failures++;
            $display("FAIL basic_frame_cnt got=%0d required=1", frame_cnt);
        end
    endtask

    task automatic test_gapped_drop();
        int mv; logic [W-1:0] d; logic e; bit got, stab; int v0;
        clear_logs();
        v0 = viol;
        core_busy_len = $urandom_range(2, 30);
        core_final = W'($urandom);
        drive_words(NLOAD, 3, 2, 1'b1, '0);
        get_result(0, mv, d, e, got, stab);
        checks++;
        if (wr_dir.size() != NLOAD || hs_cyc.size() != NLOAD) begin
            failures++;
            $display("FAIL gap_counts writes=%0d handshakes=%0d required %0d", wr_dir.size(), hs_cyc.size(), NLOAD);
        end
        for (int i = 0; i < NLOAD && i < wr_dir.size() && i < hs_cyc.size(); i++) begin
            checks++;
            if (wr_dir[i] !== ADDRW'(BASE + i) || wr_dat[i] !== exp_dat[i] || wr_cyc[i] !== hs_cyc[i] + 1) begin
                failures++;
                $display("FAIL gap_write%0d got dir=%0d data=%h cyc=%0d required dir=%0d data=%h cyc=%0d",
                         i, wr_dir[i], wr_dat[i], wr_cyc[i], BASE + i, exp_dat[i], hs_cyc[i] + 1);
            end
        end
        checks++;
        if (hs_cyc.size() < 3 || hs_cyc[2] - hs_cyc[1] !== 4) begin
            failures++;
            $display("FAIL gap_held_off got spacing=%0d required=4", (hs_cyc.size() >= 3) ? hs_cyc[2] - hs_cyc[1] : -1);
        end
        checks++;
        if (viol !== v0) begin
            failures++;
            $display("FAIL gap_protocol got violations=%0d required=0", viol - v0);
        end
        checks++;
        if (!got || d !== core_final || e !== 1'b0 || frame_cnt !== 8'(fc_exp)) begin
            failures++;
            $display("FAIL gap_result got data=%h err=%b fc=%0d required data=%h err=0 fc=%0d", d, e, frame_cnt, core_final, fc_exp);
        end
    endtask

    task automatic test_start_timeout();
        int mv; logic [W-1:0] d; logic e; bit got, stab; int st;
        clear_logs();
        core_hang = 1'b1;
        drive_words(NLOAD, 1, -1, 1'b1, '0);
        get_result(0, mv, d, e, got, stab);
        repeat (5) @(negedge clk);
        core_hang = 1'b0;
        st = (st_cyc.size() > 0) ? st_cyc[0] : -1;
        checks++;
        if (!got || mv !== st + START_TO || e !== 1'b1) begin
            failures++;
            $display("FAIL start_to got mv_cyc=%0d err=%b required mv_cyc=%0d err=1", mv, e, st + START_TO);
        end
        checks++;
        if (st_cyc.size() != 1 || wr_dir.size() != NLOAD) begin
            failures++;
            $display("FAIL start_to_quiet got starts=%0d writes=%0d required 1 and %0d", st_cyc.size(), wr_dir.size(), NLOAD);
        end
        checks++;
        if (frame_cnt !== 8'(fc_exp)) begin
            failures++;
            $display("FAIL start_to_frame_cnt got=%0d required=%0d", frame_cnt, fc_exp);
        end
    endtask

    task automatic test_run_timeout();
        int mv; logic [W-1:0] d; logic e; bit got, stab; int st, v0, g;
        clear_logs();
        v0 = viol;
        core_busy_len = 1100;
        drive_words(NLOAD, 1, -1, 1'b1, '0);
        get_result(10, mv, d, e, got, stab);
        st = (st_cyc.size() > 0) ? st_cyc[0] : -1;
        checks++;
        if (!got || mv !== st + 2 + RUN_TO || e !== 1'b1) begin
            failures++;
            $display("FAIL run_to got mv_cyc=%0d err=%b required mv_cyc=%0d err=1", mv, e, st + 2 + RUN_TO);
        end
        checks++;
        if (!stab || viol !== v0) begin
            failures++;
            $display("FAIL run_to_stall got stable=%0d violations=%0d required stable=1 violations=0", stab, viol - v0);
        end
        g = 0;
        while (core_busy_left > 0 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (core_busy_left != 0 || st_cyc.size() != 1 || frame_cnt !== 8'(fc_exp)) begin
            failures++;
            $display("FAIL run_to_after got core_left=%0d starts=%0d fc=%0d required 0, 1, %0d",
                     core_busy_left, st_cyc.size(), frame_cnt, fc_exp);
        end
    endtask

    task automatic test_reset_midframe();
        int mv; logic [W-1:0] d; logic e; bit got, stab;
        core_busy_len = 6;
        drive_words(2, 1, -1, 1'b1, '0);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_ready, m_valid, m_err, m_data, kf_data_in, kf_dir, kf_write, kf_start, frame_cnt} !== '0) begin
            failures++;
            $display("FAIL midframe_reset got din=%h dir=%0d wr=%b st=%b fc=%0d m_data=%h required all 0",
                     kf_data_in, kf_dir, kf_write, kf_start, frame_cnt, m_data);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        fc_exp = 0;
        clear_logs();
        core_final = W'($urandom);
        drive_words(NLOAD, 1, -1, 1'b1, '0);
        get_result(0, mv, d, e, got, stab);
        checks++;
        if (wr_dir.size() != NLOAD || hs_cyc.size() != NLOAD) begin
            failures++;
            $display("FAIL midframe_counts writes=%0d handshakes=%0d required %0d", wr_dir.size(), hs_cyc.size(), NLOAD);
        end
        for (int i = 0; i < NLOAD && i < wr_dir.size() && i < exp_dat.size(); i++) begin
            checks++;
            if (wr_dir[i] !== ADDRW'(BASE + i) || wr_dat[i] !== exp_dat[i]) begin
                failures++;
                $display("FAIL midframe_write%0d got dir=%0d data=%h required dir=%0d data=%h",
                         i, wr_dir[i], wr_dat[i], BASE + i, exp_dat[i]);
            end
        end
        checks++;
        if (!got || d !== core_final || e !== 1'b0 || frame_cnt !== 8'd1) begin
            failures++;
            $display("FAIL midframe_result got data=%h err=%b fc=%0d required data=%h err=0 fc=1", d, e, frame_cnt, core_final);
        end
    endtask

    task automatic test_wrap();
        int mv; logic [W-1:0] d; logic e; bit got, stab; int bad_dir;
        do_reset();
        clear_logs();
        for (int f = 0; f < 256; f++) begin
            core_busy_len = $urandom_range(2, 4);
            core_final = W'($urandom);
            drive_words(NLOAD, 1, -1, 1'b1, '0);
            get_result(0, mv, d, e, got, stab);
            checks++;
            if (!got || d !== core_final || e !== 1'b0 || frame_cnt !== 8'((f + 1) % 256)) begin
                failures++;
                $display("FAIL wrap_frame%0d got data=%h err=%b fc=%0d required data=%h err=0 fc=%0d",
                         f, d, e, frame_cnt, core_final, (f + 1) % 256);
            end
        end
        bad_dir = 0;
        for (int j = 0; j < wr_dir.size(); j++)
            if (wr_dir[j] !== ADDRW'(BASE + j % NLOAD)) bad_dir++;
        checks++;
        if (st_cyc.size() != 256 || wr_dir.size() != 256 * NLOAD || bad_dir != 0) begin
            failures++;
            $display("FAIL wrap_totals got starts=%0d writes=%0d bad_dir=%0d required 256, %0d, 0",
                     st_cyc.size(), wr_dir.size(), bad_dir, 256 * NLOAD);
        end
        checks++;
        if (frame_cnt !== 8'd0) begin
            failures++;
            $display("FAIL wrap_frame_cnt got=%0d required=0", frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped_drop();
        test_start_timeout();
        test_run_timeout();
        test_reset_midframe();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation did not complete got time=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/kf_host_ctrl.md
# kf_host_ctrl

Host-side driver for the Kalman filter core's external interface. Accepts a frame of NLOAD measurement words on a valid/ready stream and writes them into consecutive Data Bank addresses while the core is idle. It then pulses START, tracks the core through its busy period, and returns the final DATA_OUT value on a valid/ready result stream. It sits between the system bus/stream fabric and the core's DATA_IN/DIR/WRITE/START/READY/DATA_OUT pins, with a timeout for a hung or non-starting core.

## Interface
- W, 24, data word width (matches core DATA_IN/DATA_OUT)
- ADDRW, 5, Data Bank address width (matches core DIR)
- NLOAD, 4, words per frame, 1..2^ADDRW
- BASE_ADDR, 0, first Data Bank address written; BASE_ADDR+NLOAD-1 must be < 2^ADDRW
- START_TO, 15, max cycles waiting for READY to fall after START
- RUN_TO, 1023, max cycles waiting for READY to return high
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_valid  in  1  measurement word valid
- s_ready  out  1  controller accepts word
- s_data  in  W  measurement word
- m_valid  out  1  result valid
- m_ready  in  1  result consumer ready
- m_data  out  W  result word (final core DATA_OUT)
- m_err  out  1  qualifies m_data: 1 = timeout, m_data undefined-but-stable
- kf_ready  in  1  core READY
- kf_data_out  in  W  core DATA_OUT
- kf_data_in  out  W  to core DATA_IN
- kf_dir  out  ADDRW  to core DIR
- kf_write  out  1  to core WRITE
- kf_start  out  1  to core START
- frame_cnt  out  8  completed frames (incl. errored), wraps 255->0

## Operation
- Reset: state IDLE; all outputs 0 (s_ready, m_valid, m_err, m_data, kf_* , frame_cnt); word counter and timers 0.
- IDLE -> LOAD when kf_ready=1.
- LOAD: s_ready = kf_ready (combinational, only in LOAD). Handshake (s_valid & s_ready) registers kf_data_in=s_data, kf_dir=BASE_ADDR+cnt, kf_write=1 for exactly one cycle; cnt increments. kf_write is 0 on any cycle without a preceding handshake. If kf_ready drops in LOAD, s_ready=0, words are held off, no error.
- After the NLOAD-th handshake -> START. START: kf_start=1 for one cycle (the cycle after the last kf_write), kf_write=0; -> WAIT_BUSY.
- WAIT_BUSY: timer counts; kf_ready=0 -> WAIT_DONE (timer cleared); timer reaching START_TO -> OUT with m_err=1.
- WAIT_DONE: each cycle with kf_ready=0, register kf_data_out into m_data. kf_ready=1 -> OUT, m_err=0 (m_data holds last busy-cycle sample). Timer reaching RUN_TO -> OUT, m_err=1.
- OUT: m_valid=1, m_data/m_err stable until m_valid & m_ready; on handshake frame_cnt++, cnt cleared, -> IDLE.
- No kf_write or kf_start is ever driven outside LOAD/START; kf_dir/kf_data_in hold last value otherwise.
- rst_n low in any state: immediate return to reset values; partially loaded frame discarded.

## Timing
- Word latency: s handshake at cycle t -> kf_write=1 at t+1 with matching kf_dir/kf_data_in.
- Max throughput: 1 word/cycle in LOAD; frame load = NLOAD cycles min.
- kf_start at (last handshake)+2 cycles... precisely: last handshake t, kf_write at t+1, kf_start at t+2.
- m_valid asserts the cycle after kf_ready is sampled high in WAIT_DONE, or the cycle after a timer expires.
- s_ready=0 in every state except LOAD; m_valid=1 only in OUT.
- Timers count cycles spent in the state; expiry compared with >=, so WAIT_BUSY gives up after START_TO cycles.

## Test plan
- NLOAD=4, BASE_ADDR=8, words 0x000100..0x000103 back-to-back, core model busy 20 cycles ending DATA_OUT=0x00ABCD -> writes to DIR 8..11 on consecutive cycles, one kf_start pulse, m_data=0x00ABCD, m_err=0, frame_cnt=1.
- s_valid gapped (one word every 3 cycles) and kf_ready dropped for 2 cycles mid-load -> no s_ready/write during the drop, exactly 4 writes, correct addresses.
- Core never drops READY after START -> after 15 cycles m_valid=1, m_err=1, no further kf_write/kf_start.
- Core busy > 1023 cycles -> m_err=1 at timeout; m_ready held 0 for 10 cycles -> m_data/m_err stable, s_ready=0 throughout.
- rst_n asserted after 2 of 4 words loaded -> all outputs 0 immediately; next frame starts at BASE_ADDR, cnt=0.
- 256 consecutive frames -> frame_cnt wraps to 0, no missed or duplicated START.
